sprite_blitter: RTL and testbench

Sprite copy engine that drives the address side of the synchronous sprite ROM (12-bit RGB, 1-cycle read latency, row-major, 20×20 = 400 words) and writes the returned pixels into the frame-buffer RAM.

- On a `start` pulse it latches a screen position, then walks every ROM address once.
- It compensates for the ROM latency and drops transparent (key-colour) pixels.
- It clips pixels that fall off-screen.
- It sits between the game-logic FSM, which issues `start`, and the frame-buffer write port.

---
 rtl/sprite_blitter_pkg.sv | 19 +
 rtl/sprite_blitter_counter.sv | 51 +++++
 rtl/sprite_blitter.sv | 135 +++++++++++++
 tb/tb_sprite_blitter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_blitter_pkg.sv
// Video parameters and blitter state encodings shared by the sprite blitter,
// the frame buffer and the VGA scan-out.
package sprite_blitter_pkg;

  localparam int          VP_FB_W          = 320;
  localparam int          VP_FB_H          = 240;
  localparam int          VP_FB_ADDR_WIDTH = 17;
  localparam int          VP_SPRITE_W      = 20;
  localparam int          VP_SPRITE_H      = 20;
  localparam logic [11:0] VP_KEY_COLOR     = 12'h0F0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;

endpackage

// File: rtl/sprite_blitter_counter.sv
// Row-major col/row walker with a linear address and last-address flag.
// Zero latency: outputs are the registered position; advances only on i_en, no backpressure.
module blit_counter
  import sprite_blitter_pkg::*;
#(
  parameter int W  = VP_SPRITE_W,
  parameter int H  = VP_SPRITE_H,
  parameter int AW = 20,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_en) begin
      if (r_col == CW'(W - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_addr = r_addr;
  assign o_last = (r_addr == AW'(W * H - 1));

endmodule

// File: rtl/sprite_blitter.sv
// Copies a sprite from a 1-cycle sync ROM into the frame buffer, keying and clipping pixels.
// Pixel n is written 2 cycles after its ROM address; no backpressure, one pixel per cycle.
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 12,
  parameter int                    ROM_ADDR_WIDTH = 20,
  parameter int                    SPRITE_W       = VP_SPRITE_W,
  parameter int                    SPRITE_H       = VP_SPRITE_H,
  parameter int                    FB_W           = VP_FB_W,
  parameter int                    FB_H           = VP_FB_H,
  parameter int                    FB_ADDR_WIDTH  = VP_FB_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR      = VP_KEY_COLOR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [9:0]                pos_x,
  input  logic [9:0]                pos_y,
  output logic                      busy,
  output logic                      done,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_data,
  output logic                      fb_we,
  output logic [FB_ADDR_WIDTH-1:0]  fb_addr,
  output logic [DATA_WIDTH-1:0]     fb_data
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);

  blit_state_t r_state, w_state_nxt;
  logic        r_drain;
  logic        w_clr, w_en, w_last;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [9:0]  r_pos_x, r_pos_y;
  logic [10:0] w_x, w_y;
  logic        r_s_vld;
  logic [10:0] r_s_x, r_s_y;
  logic        w_hit;
  logic [FB_ADDR_WIDTH-1:0] w_fb_addr;

  blit_counter #(
    .W (SPRITE_W),
    .H (SPRITE_H),
    .AW(ROM_ADDR_WIDTH),
    .CW(CW),
    .RW(RW)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_col (w_col),
    .o_row (w_row),
    .o_addr(rom_addr),
    .o_last(w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_drain <= 1'b0;
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
      if (r_state == ST_IDLE && start) begin
        r_pos_x <= pos_x;
        r_pos_y <= pos_y;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_last) w_state_nxt = ST_DRAIN;
        else        w_en        = 1'b1;
      end
      ST_DRAIN: if (r_drain) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign done = (r_state == ST_DONE);

  // Destination is 11 bits wide so that off-screen positions never wrap back on-screen.
  assign w_x = {1'b0, r_pos_x} + 11'(w_col);
  assign w_y = {1'b0, r_pos_y} + 11'(w_row);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_vld <= 1'b0;
      r_s_x   <= '0;
      r_s_y   <= '0;
    end else begin
      r_s_vld <= (r_state == ST_FETCH);
      r_s_x   <= w_x;
      r_s_y   <= w_y;
    end
  end

  assign w_hit = r_s_vld && (rom_data != KEY_COLOR) &&
                 (r_s_x < 11'(FB_W)) && (r_s_y < 11'(FB_H));
  assign w_fb_addr = FB_ADDR_WIDTH'(32'(r_s_y) * 32'(FB_W) + 32'(r_s_x));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= w_hit;
      if (w_hit) begin
        fb_addr <= w_fb_addr;
        fb_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: stimulus pushes expected writes/done cycles,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  pos_x = '0, pos_y = '0;
  logic        busy, done, fb_we;
  logic [19:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  wr_log[$];
  int  checks = 0, errors = 0;
  int  cyc = 0;
  int  rom_mode = 0;
  wr_t mon_e;

  sprite_blitter dut (
    .clk(clk), .reset(reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [11:0] rom_fn(input int n);
    if (rom_mode == 0) return 12'hFFF;
    return 12'(n);
  endfunction

  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Expected frame-buffer traffic for one blit whose start is sampled in cycle t0.
  task automatic push_expected(input int t0, input int px, input int py);
    for (int n = 0; n < 400; n++) begin
      int x, y, d;
      x = px + n % 20;
      y = py + n / 20;
      d = int'(rom_fn(n));
      if (d != 12'h0F0 && x < 320 && y < 240)
        exp_q.push_back('{cyc: t0 + n + 3, addr: y * 320 + x, data: d});
    end
    done_q.push_back(t0 + 403);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (fb_we) begin
        wr_log.push_back(int'(fb_addr));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d at cycle %0d, none required", fb_addr, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_cycle", cyc, mon_e.cyc);
          check("wr_addr", int'(fb_addr), mon_e.addr);
          check("wr_data", int'(fb_data), mon_e.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done at cycle %0d, none required", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
  endtask

  // One blit from an idle DUT; idx >= 0 selects two consecutive logged writes to spot-check.
  task automatic run_blit(input int px, input int py, input int n_wr,
                          input int first_a, input int last_a,
                          input int idx, input int va, input int vb);
    int t0, busy_cnt;
    @(negedge clk);
    t0 = cyc;
    wr_log.delete();
    push_expected(t0, px, py);
    pos_x = 10'(px);
    pos_y = 10'(py);
    start = 1'b1;
    busy_cnt = 0;
    for (int i = 1; i <= 403; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (i <= 400) check("rom_addr", int'(rom_addr), i - 1);
      else if (i < 403) check("rom_addr_hold", int'(rom_addr), 399);
    end
    check("done_at_403", int'(done), 1);
    check("busy_at_403", int'(busy), 0);
    check("busy_cycles", busy_cnt, 402);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("write_count", wr_log.size(), n_wr);
    check("exp_left", exp_q.size(), 0);
    check("done_left", done_q.size(), 0);
    if (n_wr > 0 && wr_log.size() == n_wr) begin
      check("first_addr", wr_log[0], first_a);
      check("last_addr", wr_log[n_wr - 1], last_a);
    end
    if (idx >= 0 && wr_log.size() > idx + 1) begin
      check("row_step_a", wr_log[idx], va);
      check("row_step_b", wr_log[idx + 1], vb);
    end
  endtask

  initial begin
    int t0;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    rom_mode = 0;
    run_blit(0, 0, 400, 0, 6099, 19, 19, 320);
    rom_mode = 1;
    run_blit(100, 50, 399, 16100, 22199, 19, 16119, 16420);
    rom_mode = 0;
    run_blit(310, 230, 100, 73910, 76799, 9, 73919, 74230);
    run_blit(1023, 1023, 0, 0, 0, -1, 0, 0);

    // start held high: acceptances at t0, t0+404, t0+808
    @(negedge clk);
    t0 = cyc;
    for (int b = 0; b < 3; b++) push_expected(t0 + 404 * b, 0, 0);
    pos_x = '0;
    pos_y = '0;
    start = 1'b1;
    for (int i = 1; i <= 1212; i++) begin
      @(negedge clk);
      if (i == 1 || i == 405 || i == 809) begin
        check("held_busy", int'(busy), 1);
        check("held_rom_addr0", int'(rom_addr), 0);
      end
      if (i == 403 || i == 404 || i == 807 || i == 1211)
        check("held_gap_busy", int'(busy), 0);
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("held_exp_left", exp_q.size(), 0);
    check("held_done_left", done_q.size(), 0);
    check("held_idle", int'(busy), 0);

    // reset in cycle 200 of a blit
    @(negedge clk);
    t0 = cyc;
    push_expected(t0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    check("post_reset_busy", int'(busy), 0);
    run_blit(0, 0, 400, 0, 6099, 19, 19, 320);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
